// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants and the load-immediate expander state type.
// Helper encoders keep the field order for U-type and I-type words in one place.
package rv32_pkg;

    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [2:0] F3_ADDI = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_EMIT_FIRST  = 2'd1,
        ST_EMIT_SECOND = 2'd2
    } li_state_t;

    function automatic logic [31:0] enc_lui(
        input logic [19:0] imm,
        input logic [4:0]  rd
    );
        return {imm, rd, OP_LUI};
    endfunction

    function automatic logic [31:0] enc_addi(
        input logic [11:0] imm,
        input logic [4:0]  rs1,
        input logic [4:0]  rd
    );
        return {imm, rs1, F3_ADDI, rd, OP_IMM};
    endfunction

endpackage

// File: rtl/li_split.sv
// Splits a 32-bit constant into the LUI upper immediate and ADDI low immediate.
// The upper half is pre-rounded so that a sign-extended lo12 lands on the value.
module li_split (
    input  logic [31:0] i_value,
    output logic [19:0] o_hi20,
    output logic [11:0] o_lo12,
    output logic        o_fits12,
    output logic        o_lo_zero
);

    logic [20:0] w_top;

    assign w_top = i_value[31:11];

    // Adding 0x800 only carries into bit 12 when bit 11 is set.
    assign o_hi20    = i_value[31:12] + {19'd0, i_value[11]};
    assign o_lo12    = i_value[11:0];
    assign o_fits12  = (&w_top) | ~(|w_top);
    assign o_lo_zero = ~(|i_value[11:0]);

endmodule

// File: rtl/li_expander.sv
// Load-immediate expander: turns a 32-bit constant into ADDI, LUI or LUI+ADDI.
// Output word, last flag and valid are registered; in_ready decodes the state.
module li_expander
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_last,
    output logic [15:0] emitted_cnt
);

    li_state_t   r_state;
    logic [11:0] r_lo12;
    logic [4:0]  r_rd;
    logic        r_two;
    logic        r_out_valid;
    logic [31:0] r_out_word;
    logic        r_out_last;
    logic [15:0] r_cnt;

    logic [19:0] w_hi20;
    logic [11:0] w_lo12;
    logic        w_fits12;
    logic        w_lo_zero;
    logic        w_single;
    logic [31:0] w_first;
    logic        w_accept;
    logic        w_xfer;

    li_split u_split (
        .i_value   (in_value),
        .o_hi20    (w_hi20),
        .o_lo12    (w_lo12),
        .o_fits12  (w_fits12),
        .o_lo_zero (w_lo_zero)
    );

    assign w_single = w_fits12 | w_lo_zero;
    assign w_first  = w_fits12 ? enc_addi(w_lo12, 5'd0, in_rd)
                               : enc_lui(w_hi20, in_rd);

    assign in_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_lo12      <= 12'd0;
            r_rd        <= 5'd0;
            r_two       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_word  <= 32'd0;
            r_out_last  <= 1'b0;
            r_cnt       <= 16'd0;
        end else begin
            if (w_xfer) begin
                r_cnt <= r_cnt + 16'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_lo12      <= w_lo12;
                        r_rd        <= in_rd;
                        r_two       <= ~w_single;
                        r_out_valid <= 1'b1;
                        r_out_word  <= w_first;
                        r_out_last  <= w_single;
                        r_state     <= ST_EMIT_FIRST;
                    end
                end
                ST_EMIT_FIRST: begin
                    if (out_ready) begin
                        if (r_two) begin
                            r_out_word <= enc_addi(r_lo12, r_rd, r_rd);
                            r_out_last <= 1'b1;
                            r_state    <= ST_EMIT_SECOND;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                ST_EMIT_SECOND: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign out_word    = r_out_word;
    assign out_last    = r_out_last;
    assign emitted_cnt = r_cnt;

endmodule

// File: tb/tb_li_expander.sv
// Directed bench for li_expander: vector table plus backpressure and reset cases.
// Expected encodings are worked out by hand from the RV32I field layout.
module tb_li_expander;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_last;
    logic [15:0] emitted_cnt;

    int checks;
    int errors;
    int exp_cnt;

    typedef struct {
        logic [31:0] value;
        logic [4:0]  rd;
        int          nwords;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs[8];

    li_expander dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_value    (in_value),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_last    (out_last),
        .emitted_cnt (emitted_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] v, input logic [4:0] rd);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        in_valid = 1'b1;
        in_value = v;
        in_rd    = rd;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv(input string name, input logic [31:0] w,
                        input logic last);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: out_valid got 0 expected 1", name);
        end else begin
            check({name, "_word"}, out_word, w);
            check({name, "_last"}, {31'd0, out_last}, {31'd0, last});
        end
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_cnt   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_value  = 32'd0;
        in_rd     = 5'd0;
        out_ready = 1'b1;

        vecs[0] = '{32'h12345678, 5'd5,  2, 32'h123452B7, 32'h67828293};
        vecs[1] = '{32'h00000FFF, 5'd5,  2, 32'h000012B7, 32'hFFF28293};
        vecs[2] = '{32'hFFFFF800, 5'd1,  1, 32'h80000093, 32'h0};
        vecs[3] = '{32'h00000000, 5'd3,  1, 32'h00000193, 32'h0};
        vecs[4] = '{32'h80000000, 5'd10, 1, 32'h80000537, 32'h0};
        vecs[5] = '{32'h000007FF, 5'd2,  1, 32'h7FF00113, 32'h0};
        vecs[6] = '{32'hFFFFF7FF, 5'd7,  2, 32'hFFFFF3B7, 32'h7FF38393};
        vecs[7] = '{32'h7FFFF800, 5'd0,  2, 32'h80000037, 32'h80000013};

        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_word", out_word, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_cnt", {16'd0, emitted_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].value, vecs[i].rd);
            recv($sformatf("v%0d_w0", i), vecs[i].w0, vecs[i].nwords == 1);
            if (vecs[i].nwords == 2)
                recv($sformatf("v%0d_w1", i), vecs[i].w1, 1'b1);
            exp_cnt += vecs[i].nwords;
            check($sformatf("v%0d_idle_valid", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            check($sformatf("v%0d_cnt", i), {16'd0, emitted_cnt}, exp_cnt);
        end

        // Backpressure on both words of a pair
        out_ready = 1'b0;
        send(32'h12345678, 5'd5);
        for (int k = 0; k < 3; k++) begin
            check("bp0_valid", {31'd0, out_valid}, 32'd1);
            check("bp0_word", out_word, 32'h123452B7);
            check("bp0_last", {31'd0, out_last}, 32'd0);
            check("bp0_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        check("bp0_cnt", {16'd0, emitted_cnt}, exp_cnt);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt++;
        for (int k = 0; k < 3; k++) begin
            check("bp1_valid", {31'd0, out_valid}, 32'd1);
            check("bp1_word", out_word, 32'h67828293);
            check("bp1_last", {31'd0, out_last}, 32'd1);
            check("bp1_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp1_cnt", {16'd0, emitted_cnt}, exp_cnt);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        check("bp_done_valid", {31'd0, out_valid}, 32'd0);
        check("bp_done_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_done_cnt", {16'd0, emitted_cnt}, exp_cnt);

        // Reset while the ADDI of a pair is stalled
        out_ready = 1'b0;
        send(32'h12345678, 5'd5);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        check("stall2_word", out_word, 32'h67828293);
        check("stall2_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_cnt", {16'd0, emitted_cnt}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        send(32'h80000000, 5'd10);
        recv("fresh_w0", 32'h80000537, 1'b1);
        check("fresh_no_stale", {31'd0, out_valid}, 32'd0);
        check("fresh_cnt", {16'd0, emitted_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
